// File: rtl/btn_irq.sv
// ---------------------------------------------------------------------------
// btn_irq -- push-button interrupt-source front end for the n_clic controller.
//
// Each raw button input is synchronised, debounced by a 4-state FSM, and the
// selected edge of the debounced level raises a pending line. The n_clic
// clears a pending line with a one-cycle acknowledge. An edge that arrives
// while its pending line is still set (and not being acknowledged) sets a
// sticky overrun flag, which the next acknowledge clears.
//
// Parameters:
//   NumBtn         number of button channels
//   SyncStages     synchroniser depth (>= 2)
//   DebounceCycles consecutive stable synchronised cycles needed to accept a
//                  new level (>= 2)
//
// Ports:
//   clk        in   core clock
//   reset      in   asynchronous active-low reset
//   btn_in     in   [NumBtn] raw asynchronous button inputs
//   edge_sel   in   [NumBtn] 0 = rising edge pends, 1 = falling edge pends
//   irq_ack    in   [NumBtn] one-cycle clear from n_clic
//   edge_both  in   [NumBtn] only with BTN_IRQ_BOTH_EDGES_EN: both edges pend,
//                   edge_sel ignored for that channel
//   btn_level  out  [NumBtn] debounced level (registered)
//   irq_pend   out  [NumBtn] pending interrupt request (registered)
//   overrun    out  [NumBtn] sticky lost-edge flag (registered)
//
// Build option: define BTN_IRQ_BOTH_EDGES_EN to add the edge_both port.
// Without it the logic behaves as if edge_both were tied to 0.
// ---------------------------------------------------------------------------
module btn_irq #(
  parameter int NumBtn         = 4,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NumBtn-1:0] btn_in,
  input  logic [NumBtn-1:0] edge_sel,
  input  logic [NumBtn-1:0] irq_ack,
`ifdef BTN_IRQ_BOTH_EDGES_EN
  input  logic [NumBtn-1:0] edge_both,
`endif
  output logic [NumBtn-1:0] btn_level,
  output logic [NumBtn-1:0] irq_pend,
  output logic [NumBtn-1:0] overrun
);

  localparam int CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntZero = CntW'(0);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_RISE = 2'd1,
    S_HI   = 2'd2,
    S_FALL = 2'd3
  } state_e;

  logic [NumBtn-1:0] sync_r [SyncStages];
  logic [NumBtn-1:0] sync_s;
  logic [NumBtn-1:0] edge_both_s;

  assign sync_s = sync_r[SyncStages-1];

`ifdef BTN_IRQ_BOTH_EDGES_EN
  assign edge_both_s = edge_both;
`else
  assign edge_both_s = {NumBtn{1'b0}};
`endif

  // Synchroniser chain for the raw asynchronous button inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_r[s] <= {NumBtn{1'b0}};
      end
    end else begin
      sync_r[0] <= btn_in;
      for (int s = 1; s < SyncStages; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  for (genvar g = 0; g < NumBtn; g++) begin : g_ch
    state_e          state_r;
    logic [CntW-1:0] cnt_r;
    logic            level_r;
    logic            pend_r;
    logic            ovr_r;
    logic            rise_s;
    logic            fall_s;
    logic            evt_s;

    // Decode the debounce completions that fire on this cycle's edge.
    always_comb begin
      rise_s = 1'b0;
      fall_s = 1'b0;
      case (state_r)
        S_RISE: begin
          if (sync_s[g] && (cnt_r == CntLast)) begin
            rise_s = 1'b1;
          end else begin
            rise_s = 1'b0;
          end
        end
        S_FALL: begin
          if (!sync_s[g] && (cnt_r == CntLast)) begin
            fall_s = 1'b1;
          end else begin
            fall_s = 1'b0;
          end
        end
        default: begin
          rise_s = 1'b0;
          fall_s = 1'b0;
        end
      endcase
    end

    // Edge qualification; edge_sel is looked at only when an edge fires.
    always_comb begin
      if (edge_both_s[g]) begin
        evt_s = rise_s | fall_s;
      end else begin
        evt_s = (rise_s & ~edge_sel[g]) | (fall_s & edge_sel[g]);
      end
    end

    // Debounce FSM: a new level needs DebounceCycles stable samples.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_r <= S_LO;
        cnt_r   <= CntZero;
        level_r <= 1'b0;
      end else begin
        case (state_r)
          S_LO: begin
            if (sync_s[g]) begin
              state_r <= S_RISE;
              cnt_r   <= CntOne;
            end else begin
              cnt_r   <= CntZero;
            end
          end
          S_RISE: begin
            if (!sync_s[g]) begin
              state_r <= S_LO;
              cnt_r   <= CntZero;
            end else if (cnt_r == CntLast) begin
              state_r <= S_HI;
              cnt_r   <= CntZero;
              level_r <= 1'b1;
            end else begin
              cnt_r   <= cnt_r + CntOne;
            end
          end
          S_HI: begin
            if (!sync_s[g]) begin
              state_r <= S_FALL;
              cnt_r   <= CntOne;
            end else begin
              cnt_r   <= CntZero;
            end
          end
          S_FALL: begin
            if (sync_s[g]) begin
              state_r <= S_HI;
              cnt_r   <= CntZero;
            end else if (cnt_r == CntLast) begin
              state_r <= S_LO;
              cnt_r   <= CntZero;
              level_r <= 1'b0;
            end else begin
              cnt_r   <= cnt_r + CntOne;
            end
          end
          default: begin
            state_r <= S_LO;
            cnt_r   <= CntZero;
            level_r <= 1'b0;
          end
        endcase
      end
    end

    // Pending/overrun update: a new event always beats a coincident ack.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pend_r <= 1'b0;
        ovr_r  <= 1'b0;
      end else begin
        if (evt_s && pend_r && !irq_ack[g]) begin
          pend_r <= 1'b1;
          ovr_r  <= 1'b1;
        end else if (evt_s) begin
          pend_r <= 1'b1;
        end else if (irq_ack[g]) begin
          pend_r <= 1'b0;
          ovr_r  <= 1'b0;
        end else begin
          pend_r <= pend_r;
          ovr_r  <= ovr_r;
        end
      end
    end

    assign btn_level[g] = level_r;
    assign irq_pend[g]  = pend_r;
    assign overrun[g]   = ovr_r;
  end

endmodule

// File: tb/tb_btn_irq.sv
// ---------------------------------------------------------------------------
// tb_btn_irq -- self-checking bench for btn_irq (SyncStages=2,
// DebounceCycles=4). A table of settle-and-check rows covers the steady
// behaviour; hand-written sequences cover exact latency, glitch rejection,
// event/ack coincidence, async reset mid-count and (when built with
// BTN_IRQ_BOTH_EDGES_EN) both-edge pending. Expected outputs are pushed to a
// scoreboard queue when stimulus is driven and popped when sampled.
// ---------------------------------------------------------------------------
module tb_btn_irq;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] edge_sel;
  logic [3:0] irq_ack;
  logic [3:0] edge_both;
  logic [3:0] btn_level;
  logic [3:0] irq_pend;
  logic [3:0] overrun;

  int total;
  int bad;

  btn_irq #(
    .NumBtn(4),
    .SyncStages(2),
    .DebounceCycles(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .edge_sel(edge_sel),
    .irq_ack(irq_ack),
`ifdef BTN_IRQ_BOTH_EDGES_EN
    .edge_both(edge_both),
`endif
    .btn_level(btn_level),
    .irq_pend(irq_pend),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] pend;
    logic [3:0] ov;
  } exp_t;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] sel;
    logic [3:0] ack;
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] pend;
    logic [3:0] ov;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[17];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [3:0] l, input logic [3:0] p, input logic [3:0] o);
    exp_t e;
    e.lvl  = l;
    e.pend = p;
    e.ov   = o;
    sbq.push_back(e);
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sbq.pop_front();
      if ({btn_level, irq_pend, overrun} !== {e.lvl, e.pend, e.ov}) begin
        bad++;
        $display("FAIL %s: got lvl=%b pend=%b ovr=%b, want lvl=%b pend=%b ovr=%b",
                 name, btn_level, irq_pend, overrun, e.lvl, e.pend, e.ov);
      end
    end
  endtask

  // One-cycle acknowledge pulse on the given channels.
  task automatic ack_pulse(input logic [3:0] a);
    irq_ack = a;
    tick(1);
    irq_ack = 4'b0000;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    btn_in    = 4'b0000;
    edge_sel  = 4'b0000;
    irq_ack   = 4'b0000;
    edge_both = 4'b0000;

    //               btn      sel      ack      cyc lvl      pend     ov
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 20, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 8,  4'b0001, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0001, 4'b0000, 4'b0001, 2,  4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 8,  4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0100, 4'b0100, 4'b0000, 8,  4'b0100, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0100, 4'b0000, 8,  4'b0000, 4'b0100, 4'b0000};
    tbl[6]  = '{4'b0100, 4'b0100, 4'b0000, 8,  4'b0100, 4'b0100, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0100, 4'b0000, 8,  4'b0000, 4'b0100, 4'b0100};
    tbl[8]  = '{4'b0000, 4'b0100, 4'b0100, 2,  4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b1111, 2,  4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1111, 4'b0000, 4'b0000, 8,  4'b1111, 4'b1111, 4'b0000};
    tbl[11] = '{4'b0000, 4'b1111, 4'b0000, 8,  4'b0000, 4'b1111, 4'b1111};
    tbl[12] = '{4'b0000, 4'b1111, 4'b1111, 2,  4'b0000, 4'b0000, 4'b0000};
    tbl[13] = '{4'b1010, 4'b1000, 4'b0000, 8,  4'b1010, 4'b0010, 4'b0000};
    tbl[14] = '{4'b1010, 4'b1000, 4'b0010, 2,  4'b1010, 4'b0000, 4'b0000};
    tbl[15] = '{4'b0000, 4'b1000, 4'b0000, 8,  4'b0000, 4'b1000, 4'b0000};
    tbl[16] = '{4'b0000, 4'b1000, 4'b1000, 2,  4'b0000, 4'b0000, 4'b0000};

    // Reset state.
    tick(3);
    push_exp(4'b0000, 4'b0000, 4'b0000);
    check_pop("reset_state");
    reset = 1'b1;

    // Table rows: drive, let the channels settle, compare.
    for (int i = 0; i < 17; i++) begin
      btn_in   = tbl[i].btn;
      edge_sel = tbl[i].sel;
      irq_ack  = tbl[i].ack;
      push_exp(tbl[i].lvl, tbl[i].pend, tbl[i].ov);
      tick(1);
      irq_ack = 4'b0000;
      tick(tbl[i].cyc - 1);
      check_pop($sformatf("row%0d", i));
    end

    // Exact latency: input sampled at edge k, outputs change at edge k+5.
    edge_sel = 4'b0000;
    btn_in   = 4'b0001;
    push_exp(4'b0000, 4'b0000, 4'b0000);
    tick(5);
    check_pop("latency_before");
    push_exp(4'b0001, 4'b0001, 4'b0000);
    tick(1);
    check_pop("latency_at");
    tick(3);
    push_exp(4'b0001, 4'b0000, 4'b0000);
    ack_pulse(4'b0001);
    check_pop("ack_clears");
    btn_in = 4'b0000;
    push_exp(4'b0000, 4'b0000, 4'b0000);
    tick(8);
    check_pop("release_no_pend");

    // Glitch reject: 3-cycle pulse on ch1 never changes anything.
    btn_in = 4'b0010;
    tick(3);
    btn_in = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      push_exp(4'b0000, 4'b0000, 4'b0000);
      tick(1);
      check_pop($sformatf("glitch_c%0d", c));
    end
    // A 4-cycle pulse is just long enough to be accepted.
    btn_in = 4'b0010;
    tick(4);
    btn_in = 4'b0000;
    push_exp(4'b0000, 4'b0010, 4'b0000);
    tick(10);
    check_pop("pulse4_accepted");
    push_exp(4'b0000, 4'b0000, 4'b0000);
    ack_pulse(4'b0010);
    check_pop("pulse4_ack");

    // Ack coincident with a new fall event on ch3: event wins, no overrun.
    edge_sel = 4'b0000;
    btn_in   = 4'b1000;
    push_exp(4'b1000, 4'b1000, 4'b0000);
    tick(8);
    check_pop("coinc_setup");
    edge_sel = 4'b1000;
    btn_in   = 4'b0000;
    push_exp(4'b1000, 4'b1000, 4'b0000);
    tick(5);
    check_pop("coinc_before");
    push_exp(4'b0000, 4'b1000, 4'b0000);
    ack_pulse(4'b1000);
    check_pop("coinc_event_wins");
    push_exp(4'b0000, 4'b0000, 4'b0000);
    ack_pulse(4'b1000);
    check_pop("coinc_cleanup");

    // Async reset mid-count: outputs clear before the next clock edge.
    edge_sel = 4'b0000;
    btn_in   = 4'b0010;
    push_exp(4'b0010, 4'b0010, 4'b0000);
    tick(8);
    check_pop("arst_setup");
    btn_in = 4'b0011;
    tick(4);
    #3;
    reset = 1'b0;
    #1;
    push_exp(4'b0000, 4'b0000, 4'b0000);
    check_pop("arst_immediate");
    #1;
    reset = 1'b1;
    push_exp(4'b0000, 4'b0000, 4'b0000);
    tick(5);
    check_pop("arst_no_pend_yet");
    push_exp(4'b0011, 4'b0011, 4'b0000);
    tick(1);
    check_pop("arst_rearmed");
    btn_in = 4'b0000;
    ack_pulse(4'b0011);
    push_exp(4'b0000, 4'b0000, 4'b0000);
    tick(8);
    check_pop("arst_cleanup");

`ifdef BTN_IRQ_BOTH_EDGES_EN
    // Both-edge mode on ch0: edge_sel ignored, press and release both pend.
    edge_both = 4'b0001;
    edge_sel  = 4'b0001;
    btn_in    = 4'b0001;
    push_exp(4'b0001, 4'b0001, 4'b0000);
    tick(8);
    check_pop("both_press");
    push_exp(4'b0001, 4'b0000, 4'b0000);
    ack_pulse(4'b0001);
    check_pop("both_ack1");
    btn_in = 4'b0000;
    push_exp(4'b0000, 4'b0001, 4'b0000);
    tick(8);
    check_pop("both_release");
    push_exp(4'b0000, 4'b0000, 4'b0000);
    ack_pulse(4'b0001);
    check_pop("both_ack2");
    edge_both = 4'b0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
